// File: rtl/chs_pkg.sv
// Shared types, field positions and the error-to-power helper for the
// CoolHeatSystem thermostat controller.
package chs_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_HEAT  = 3'd1,
    ST_COOL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam int CONF_EN_BIT   = 7;
  localparam int CONF_MODE_BIT = 6;

  // |err| >> shift, clamped to the 4-bit power range.
  function automatic logic [3:0] sat_lvl(input logic signed [8:0] err,
                                         input int unsigned shift);
    logic [8:0] mag;
    logic [8:0] sh;
    mag = err[8] ? 9'(-err) : 9'(err);
    sh  = mag >> shift;
    return (sh > 9'd15) ? 4'd15 : sh[3:0];
  endfunction

endpackage

// File: rtl/chs_speed_ramp.sv
// Fan speed slew limiter: moves one LSB toward the target every RAMP_DIV
// cycles, with a prescaler clear and an immediate force-to-zero.
module chs_speed_ramp #(
  parameter int RAMP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] target_i,
  input  logic       clr_i,
  input  logic       zero_i,
  output logic [7:0] speed_o
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    speed_q, speed_d;
  logic          step_s;

  always_comb begin
    step_s  = (pre_q == PW'(RAMP_DIV - 1));
    pre_d   = pre_q + PW'(1);
    speed_d = speed_q;
    if (clr_i || step_s) begin
      pre_d = '0;
    end
    if (zero_i) begin
      speed_d = 8'd0;
    end else if (step_s && (speed_q < target_i)) begin
      speed_d = speed_q + 8'd1;
    end else if (step_s && (speed_q > target_i)) begin
      speed_d = speed_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      speed_q <= 8'd0;
    end else begin
      pre_q   <= pre_d;
      speed_q <= speed_d;
    end
  end

  assign speed_o = speed_q;

endmodule

// File: rtl/chs_thermostat_ctrl.sv
// Hysteresis thermostat: picks heat/cool/off from sampled temperature,
// enforces a drain + dead time between modes and faults on a stale sensor.
module chs_thermostat_ctrl
  import chs_pkg::*;
#(
  parameter int HYST      = 2,
  parameter int ERR_SHIFT = 1,
  parameter int RAMP_DIV  = 4,
  parameter int DEAD_CYC  = 20,
  parameter int TIMEOUT   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       temp_valid,
  input  logic [7:0] temp,
  input  logic [7:0] setpoint,
  output logic [7:0] chs_conf,
  output logic [7:0] speed,
  output logic [2:0] ctrl_state,
  output logic       fault
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam logic signed [8:0] HYST_S = 9'(HYST);

  state_e          state_q, state_d;
  logic [7:0]      t_reg_q, t_reg_d;
  logic            t_seen_q, t_seen_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [DW-1:0]   dead_q, dead_d;
  logic            mode_q, mode_d;
  logic [7:0]      conf_q, conf_d;
  logic            fault_q, fault_d;

  logic signed [8:0] err_s;
  logic [3:0]        lvl_s;
  logic [3:0]        lvl_act_s;
  logic              timeout_s;
  logic [7:0]        target_s;
  logic              ramp_clr_s;
  logic              ramp_zero_s;

  // A valid strobe in the threshold cycle wins over the timeout.
  always_comb begin
    err_s     = $signed({1'b0, t_reg_q}) - $signed({1'b0, setpoint});
    lvl_s     = sat_lvl(err_s, ERR_SHIFT);
    lvl_act_s = (lvl_s == 4'd0) ? 4'd1 : lvl_s;
    timeout_s = !temp_valid && (to_cnt_q == TW'(TIMEOUT));
    t_reg_d   = temp_valid ? temp : t_reg_q;
    t_seen_d  = temp_valid ? 1'b1 : t_seen_q;
    if (temp_valid) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT)) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (en && t_seen_q && !timeout_s) begin
          if (err_s < -HYST_S) begin
            state_d = ST_HEAT;
          end else if (err_s > HYST_S) begin
            state_d = ST_COOL;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_HEAT: begin
        if (timeout_s || !en || (err_s >= 9'sd0)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_HEAT;
        end
      end
      ST_COOL: begin
        if (timeout_s || !en || (err_s <= 9'sd0)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_COOL;
        end
      end
      ST_DRAIN: begin
        if (dead_q == DW'(DEAD_CYC)) begin
          state_d = timeout_s ? ST_FAULT : ST_OFF;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FAULT: begin
        state_d = temp_valid ? ST_OFF : ST_FAULT;
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Dead time only accrues once the fan has actually stopped.
  always_comb begin
    dead_d = '0;
    if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
      dead_d = (speed == 8'd0) ? dead_q + DW'(1) : dead_q;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    conf_d   = 8'd0;
    target_s = 8'd0;
    fault_d  = 1'b0;
    case (state_q)
      ST_HEAT: begin
        mode_d   = 1'b0;
        conf_d   = {1'b1, 1'b0, 2'b00, lvl_act_s};
        target_s = {lvl_act_s, 4'b0000};
      end
      ST_COOL: begin
        mode_d   = 1'b1;
        conf_d   = {1'b1, 1'b1, 2'b00, lvl_act_s};
        target_s = {lvl_act_s, 4'b0000};
      end
      ST_DRAIN: begin
        conf_d[CONF_EN_BIT]   = 1'b1;
        conf_d[CONF_MODE_BIT] = mode_q;
      end
      ST_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        conf_d = 8'd0;
      end
    endcase
    ramp_clr_s  = (state_d == ST_DRAIN) && (state_q != ST_DRAIN);
    ramp_zero_s = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      t_reg_q  <= 8'd0;
      t_seen_q <= 1'b0;
      to_cnt_q <= '0;
      dead_q   <= '0;
      mode_q   <= 1'b0;
      conf_q   <= 8'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_reg_q  <= t_reg_d;
      t_seen_q <= t_seen_d;
      to_cnt_q <= to_cnt_d;
      dead_q   <= dead_d;
      mode_q   <= mode_d;
      conf_q   <= conf_d;
      fault_q  <= fault_d;
    end
  end

  chs_speed_ramp #(
    .RAMP_DIV(RAMP_DIV)
  ) u_ramp (
    .clk     (clk),
    .rst     (rst),
    .target_i(target_s),
    .clr_i   (ramp_clr_s),
    .zero_i  (ramp_zero_s),
    .speed_o (speed)
  );

  assign chs_conf   = conf_q;
  assign ctrl_state = state_q;
  assign fault      = fault_q;

endmodule
